// File: rtl/mdu_hilo_if.sv
// Purpose: operand/command and HI/LO result bundle of the multiply-divide unit.
// Latency: none (signal bundle only).
// Backpressure: the requester must hold off start/mthi/mtlo while busy is high; they are dropped otherwise.
interface mdu_hilo_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Purpose: iterative MULT/MULTU (and DIV/DIVU when MDU_DIV_EN is defined) unit owning the HI/LO registers.
// Latency: start at edge N -> HI/LO + done at edge N+33, busy low at N+34; without MDU_DIV_EN a divide op completes at N+1.
// Backpressure: start, mthi and mtlo are silently dropped while busy is high; nothing is queued.
module mdu_hilo (
  input  logic       clk,
  input  logic       rst,
  mdu_hilo_if.slave  io_mdu
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_div;
  logic        r_neg_q;
  logic [31:0] r_ma;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
`ifdef MDU_DIV_EN
  logic [31:0] r_mb;
  logic        r_neg_r;
  logic        r_div0;
  logic [32:0] w_rem;
  logic [32:0] w_diff;
`endif

  logic        w_busy;
  logic        w_accept;
  logic        w_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_add;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_prod;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_wr;

  // busy also covers the cycle after the result write (r_done high) so the
  // result stays visible for one cycle before a new command can be taken.
  assign w_busy   = (r_state != S_IDLE) | r_done;
  assign w_accept = io_mdu.start & ~w_busy;
  assign w_signed = ~io_mdu.op[0];
  assign w_abs_a  = (w_signed & io_mdu.a[31]) ? (~io_mdu.a + 32'd1) : io_mdu.a;
  assign w_abs_b  = (w_signed & io_mdu.b[31]) ? (~io_mdu.b + 32'd1) : io_mdu.b;

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the 32nd iteration, DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MDU_DIV_EN
          w_state_nxt = S_RUN;
`else
          w_state_nxt = io_mdu.op[1] ? S_DONE : S_RUN;
`endif
        end
      end
      S_RUN:   if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration: shift-add multiply, or restoring shift-subtract divide on {remainder, quotient}.
  always_comb begin
    w_add     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_ma} : 33'd0);
    w_acc_nxt = {w_add, r_acc[31:1]};
`ifdef MDU_DIV_EN
    w_rem  = r_acc[63:31];
    w_diff = w_rem - {1'b0, r_mb};
    if (r_div) begin
      if (!w_diff[32]) w_acc_nxt = {w_diff[31:0], r_acc[30:0], 1'b1};
      else             w_acc_nxt = {w_rem[31:0],  r_acc[30:0], 1'b0};
    end
`endif
  end

  // Sign fix-up of the unsigned result and selection of what goes into HI/LO.
  always_comb begin
    w_prod   = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
`ifdef MDU_DIV_EN
    w_res_wr = (r_state == S_DONE);
    if (r_div) begin
      w_res_hi = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
      // Divide by zero: all-ones quotient; remainder already equals a after sign fix.
      if (r_div0)       w_res_lo = 32'hFFFF_FFFF;
      else if (r_neg_q) w_res_lo = ~r_acc[31:0] + 32'd1;
      else              w_res_lo = r_acc[31:0];
    end
`else
    // Divide ops pass straight through DONE without touching HI/LO.
    w_res_wr = (r_state == S_DONE) & ~r_div;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture on accept, then one iteration per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_ma    <= '0;
      r_acc   <= '0;
`ifdef MDU_DIV_EN
      r_mb    <= '0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_div   <= io_mdu.op[1];
      r_neg_q <= w_signed & (io_mdu.a[31] ^ io_mdu.b[31]);
      r_ma    <= w_abs_a;
`ifdef MDU_DIV_EN
      r_mb    <= w_abs_b;
      r_neg_r <= w_signed & io_mdu.a[31];
      r_div0  <= (io_mdu.b == 32'd0);
      r_acc   <= {32'd0, io_mdu.op[1] ? w_abs_a : w_abs_b};
`else
      r_acc   <= {32'd0, w_abs_b};
`endif
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 5'd1;
    end
  end

  // HI/LO: result write wins; mthi/mtlo only land while not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_res_wr) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (!w_busy) begin
      if (io_mdu.mthi) r_hi <= io_mdu.wdata;
      if (io_mdu.mtlo) r_lo <= io_mdu.wdata;
    end
  end

  // done pulses in the cycle after DONE, i.e. together with the HI/LO update.
  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == S_DONE);
  end

  assign io_mdu.busy = w_busy;
  assign io_mdu.done = r_done;
  assign io_mdu.hi   = r_hi;
  assign io_mdu.lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Purpose: directed, table-driven check of mdu_hilo (multiply always; divide when MDU_DIV_EN is defined).
// Latency: expects done 33 edges after start (1 for a divide without MDU_DIV_EN), busy one edge longer.
// Backpressure: drives start/mthi/mtlo while busy to confirm they are dropped.
module tb_mdu_hilo;

  logic clk = 1'b0;
  logic rst;

  mdu_hilo_if bus ();

  mdu_hilo dut (
    .clk    (clk),
    .rst    (rst),
    .io_mdu (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vt[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mt(input logic wh, input logic wl, input logic [31:0] d);
    bus.mthi  = wh;
    bus.mtlo  = wl;
    bus.wdata = d;
    tick;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
  endtask

  // Launch one op, follow it until busy drops (bounded), then watch for stray activity.
  // inj_at: cycle index at which an ignored start+mthi is driven; rst_at: cycle index of a reset pulse.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj_at, input int rst_at,
                        input int exp_done_at, input int exp_busy,
                        input logic [31:0] eh, input logic [31:0] el);
    int done_at;
    int busy_n;
    int done_n;
    int stray;
    done_at = -1;
    busy_n  = 0;
    done_n  = 0;
    stray   = 0;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done) begin
        done_n++;
        done_at = k;
      end
      if (!bus.busy) break;
      busy_n++;
      if (k == inj_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.mthi  = 1'b1;
        bus.wdata = 32'h1234;
      end
      if (k == rst_at) rst = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      rst       = 1'b0;
    end
    chk({nm, ".done_at"}, 32'(done_at), 32'(exp_done_at));
    chk({nm, ".busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    chk({nm, ".done_pulses"}, 32'(done_n), (exp_done_at < 0) ? 32'd0 : 32'd1);
    chk({nm, ".hi"}, bus.hi, eh);
    chk({nm, ".lo"}, bus.lo, el);
    for (int k = 0; k < 40; k++) begin
      if (bus.busy || bus.done) stray++;
      tick;
    end
    chk({nm, ".idle_after"}, 32'(stray), 32'd0);
  endtask

  initial begin
    logic [31:0] lo_prev;
    int          k;

    vt.push_back('{"mult_m2x3",      2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vt.push_back('{"multu_max",      2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vt.push_back('{"mult_minxmin",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vt.push_back('{"mult_m1xm1",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    vt.push_back('{"multu_shift",    2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780});
    vt.push_back('{"mult_7xm5",      2'b00, 32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD});
    vt.push_back('{"mult_0xm5",      2'b00, 32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000});
`ifdef MDU_DIV_EN
    vt.push_back('{"div_m7by2",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vt.push_back('{"divu_7by0",      2'b11, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF});
    vt.push_back('{"div_min_by_m1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vt.push_back('{"div_m7by0",      2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vt.push_back('{"divu_100by7",    2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E});
    vt.push_back('{"div_7bym2",      2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vt.push_back('{"divu_max_by2",   2'b11, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'h7FFF_FFFF});
`endif

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    tick;
    tick;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.hi", bus.hi, 32'd0);
    chk("reset.lo", bus.lo, 32'd0);
    rst = 1'b0;

    // mthi/mtlo in IDLE, separately and together.
    mt(1'b1, 1'b1, 32'h0000_ABCD);
    chk("mt_both.hi", bus.hi, 32'h0000_ABCD);
    chk("mt_both.lo", bus.lo, 32'h0000_ABCD);
    mt(1'b1, 1'b0, 32'h0000_1111);
    chk("mthi.hi", bus.hi, 32'h0000_1111);
    chk("mthi.lo", bus.lo, 32'h0000_ABCD);
    mt(1'b0, 1'b1, 32'h0000_2222);
    chk("mtlo.hi", bus.hi, 32'h0000_1111);
    chk("mtlo.lo", bus.lo, 32'h0000_2222);

    foreach (vt[i])
      run_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, -1, -1, 33, 34, vt[i].eh, vt[i].el);

    // start + mthi while busy are dropped; no second op follows.
    run_op("busy_ignore", 2'b01, 32'd5, 32'd6, 10, -1, 33, 34, 32'd0, 32'd30);

    // mthi accepted together with start, held across RUN, then overwritten by the result.
    lo_prev   = bus.lo;
    bus.op    = 2'b01;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    bus.start = 1'b1;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_0055;
    tick;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    chk("same_cycle.busy", 32'(bus.busy), 32'd1);
    chk("same_cycle.hi", bus.hi, 32'h0000_0055);
    for (int j = 0; j < 20; j++) tick;
    chk("hold_run.hi", bus.hi, 32'h0000_0055);
    chk("hold_run.lo", bus.lo, lo_prev);
    k = 0;
    while (!bus.done && k < 40) begin
      tick;
      k++;
    end
    chk("same_cycle.done", 32'(bus.done), 32'd1);
    chk("same_cycle.res_hi", bus.hi, 32'd0);
    chk("same_cycle.res_lo", bus.lo, 32'd12);
    for (int j = 0; j < 3; j++) tick;

    // Reset wins over start and mthi/mtlo in the same cycle.
    mt(1'b1, 1'b1, 32'h0000_0077);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_0099;
    tick;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    chk("rst_prio.busy", 32'(bus.busy), 32'd0);
    chk("rst_prio.hi", bus.hi, 32'd0);
    chk("rst_prio.lo", bus.lo, 32'd0);

    // Reset mid-RUN discards the operation and clears HI/LO.
    mt(1'b1, 1'b1, 32'hDEAD_BEEF);
`ifdef MDU_DIV_EN
    run_op("rst_mid_run", 2'b11, 32'd100, 32'd7, -1, 15, -1, 16, 32'd0, 32'd0);
`else
    run_op("rst_mid_run", 2'b01, 32'd100, 32'd7, -1, 15, -1, 16, 32'd0, 32'd0);
`endif

`ifndef MDU_DIV_EN
    // Divide ops without the divider: done at N+1, HI/LO untouched.
    mt(1'b1, 1'b0, 32'd1);
    mt(1'b0, 1'b1, 32'd2);
    run_op("div_disabled", 2'b10, 32'd10, 32'd3, -1, -1, 1, 2, 32'd1, 32'd2);
    run_op("divu_disabled", 2'b11, 32'd10, 32'd0, -1, -1, 1, 2, 32'd1, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
